// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding and counter width.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        HALTED = 2'b01,
        RESUME = 2'b10
    } pipe_state_t;

    localparam int CNT_WIDTH_DEF = 32;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter: +1 per enabled cycle, wraps silently.
module perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     count <= '0;
        else if (en) count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Run/halt sequencer plus stall/flush arbitration and performance counters
// for the 5-stage pipeline.
module pipeline_ctrl import pipe_pkg::*; #(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter bit GO_SYNC   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 load_use,
    input  logic                 branch_taken,
    input  logic                 jump_taken,
    input  logic                 halt_req,
    output logic                 pc_enable,
    output logic                 if_id_enable,
    output logic                 if_id_flush,
    output logic                 id_ex_enable,
    output logic                 id_ex_flush,
    output logic                 ex_mem_enable,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] total_cycles,
    output logic [CNT_WIDTH-1:0] bubble_num,
    output logic [CNT_WIDTH-1:0] condi_branch_num,
    output logic [CNT_WIDTH-1:0] uncondi_branch_num
);

    pipe_state_t state, state_nxt;
    logic        go_s, go_prev, go_rise;
    logic        active, redirect, stall;

    generate
        if (GO_SYNC) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_q <= '0;
                else     sync_q <= {sync_q[0], go};
            end
            assign go_s = sync_q[1];
        end else begin : g_nosync
            assign go_s = go;
        end
    endgenerate

    // Tracked in every state so a press held across a halt never counts twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) go_prev <= 1'b0;
        else     go_prev <= go_s;
    end
    assign go_rise = go_s & ~go_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // RESUME ignores halt_req so the syscall still in WB can retire.
    always_comb begin
        state_nxt = RUN;
        unique case (state)
            RUN:     state_nxt = halt_req ? HALTED : RUN;
            HALTED:  state_nxt = go_rise ? RESUME : HALTED;
            RESUME:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign active   = (state != HALTED);
    assign redirect = branch_taken | jump_taken;
    assign stall    = load_use & ~redirect;

    always_comb begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_enable  = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_enable = 1'b0;
        halted        = ~active;
        if (active) begin
            pc_enable     = ~stall;
            if_id_enable  = ~stall;
            if_id_flush   = redirect;
            id_ex_enable  = 1'b1;
            id_ex_flush   = redirect | stall;
            ex_mem_enable = 1'b1;
        end
    end

    perf_counter #(.WIDTH(CNT_WIDTH)) u_total (
        .clk(clk), .rst(rst), .en(active), .count(total_cycles));
    perf_counter #(.WIDTH(CNT_WIDTH)) u_bubble (
        .clk(clk), .rst(rst), .en(active & stall), .count(bubble_num));
    perf_counter #(.WIDTH(CNT_WIDTH)) u_condi (
        .clk(clk), .rst(rst), .en(active & branch_taken & ~jump_taken), .count(condi_branch_num));
    perf_counter #(.WIDTH(CNT_WIDTH)) u_uncondi (
        .clk(clk), .rst(rst), .en(active & jump_taken), .count(uncondi_branch_num));

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a 32-bit synchronised instance and a 4-bit
// unsynchronised instance share stimulus and are checked against a rule model.
module tb_pipeline_ctrl;

    logic clk, rst, go, load_use, branch_taken, jump_taken, halt_req;
    logic [1:0] pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, halted_o;
    logic [31:0] tc0, bb0, cb0, ub0;
    logic [3:0]  tc1, bb1, cb1, ub1;
    logic [6:0]  act_ctrl [2];
    logic [31:0] act_cnt [2][4];

    int checks = 0;
    int passed = 0;

    pipeline_ctrl #(.CNT_WIDTH(32), .GO_SYNC(1'b1)) dut (
        .clk(clk), .rst(rst), .go(go), .load_use(load_use),
        .branch_taken(branch_taken), .jump_taken(jump_taken), .halt_req(halt_req),
        .pc_enable(pc_en[0]), .if_id_enable(ifid_en[0]), .if_id_flush(ifid_fl[0]),
        .id_ex_enable(idex_en[0]), .id_ex_flush(idex_fl[0]), .ex_mem_enable(exmem_en[0]),
        .halted(halted_o[0]), .total_cycles(tc0), .bubble_num(bb0),
        .condi_branch_num(cb0), .uncondi_branch_num(ub0));

    pipeline_ctrl #(.CNT_WIDTH(4), .GO_SYNC(1'b0)) dut4 (
        .clk(clk), .rst(rst), .go(go), .load_use(load_use),
        .branch_taken(branch_taken), .jump_taken(jump_taken), .halt_req(halt_req),
        .pc_enable(pc_en[1]), .if_id_enable(ifid_en[1]), .if_id_flush(ifid_fl[1]),
        .id_ex_enable(idex_en[1]), .id_ex_flush(idex_fl[1]), .ex_mem_enable(exmem_en[1]),
        .halted(halted_o[1]), .total_cycles(tc1), .bubble_num(bb1),
        .condi_branch_num(cb1), .uncondi_branch_num(ub1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, halted}
    for (genvar i = 0; i < 2; i++) begin : g_act
        assign act_ctrl[i] = {pc_en[i], ifid_en[i], ifid_fl[i], idex_en[i],
                              idex_fl[i], exmem_en[i], halted_o[i]};
    end
    assign act_cnt[0][0] = tc0;
    assign act_cnt[0][1] = bb0;
    assign act_cnt[0][2] = cb0;
    assign act_cnt[0][3] = ub0;
    assign act_cnt[1][0] = {28'd0, tc1};
    assign act_cnt[1][1] = {28'd0, bb1};
    assign act_cnt[1][2] = {28'd0, cb1};
    assign act_cnt[1][3] = {28'd0, ub1};

    // Reference model: halted/resume flags, plain event tallies, history of sampled go.
    bit          m_halt [2];
    bit          m_res  [2];
    int unsigned m_cnt  [2][4];
    logic [2:0]  g_hist;

    function automatic logic [6:0] exp_ctrl(int i);
        if (m_halt[i])                   return 7'b0000001;
        if (branch_taken || jump_taken)  return 7'b1111110;
        if (load_use)                    return 7'b0001110;
        return 7'b1101010;
    endfunction

    function automatic logic [31:0] exp_cnt(int i, int k);
        return (i == 0) ? m_cnt[i][k] : (m_cnt[i][k] & 32'hF);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_halt[i] = 0;
            m_res[i]  = 0;
            for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
        end
        g_hist = '0;
    endtask

    // Advance one clock; inputs must already be set. Returns at the next falling edge.
    task automatic tick();
        bit r [2];
        @(posedge clk);
        if (rst) model_reset();
        else begin
            r[0] = g_hist[1] & ~g_hist[2];
            r[1] = go & ~g_hist[0];
            for (int i = 0; i < 2; i++) begin
                if (!m_halt[i]) begin
                    m_cnt[i][0]++;
                    if (jump_taken)        m_cnt[i][3]++;
                    else if (branch_taken) m_cnt[i][2]++;
                    else if (load_use)     m_cnt[i][1]++;
                end
                if (m_halt[i]) begin
                    if (r[i]) begin m_halt[i] = 0; m_res[i] = 1; end
                end else if (m_res[i]) m_res[i] = 0;
                else if (halt_req)     m_halt[i] = 1;
            end
            g_hist = {g_hist[1:0], go};
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        go = 0; load_use = 0; branch_taken = 0; jump_taken = 0; halt_req = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_ctrl[i] !== 7'b1101010) $display("FAIL reset_ctrl[%0d] got %b want %b", i, act_ctrl[i], 7'b1101010);
            else passed++;
            checks++;
            if (act_cnt[i][0] !== 0 || act_cnt[i][1] !== 0 || act_cnt[i][2] !== 0 || act_cnt[i][3] !== 0)
                $display("FAIL reset_cnt[%0d] got %0d/%0d/%0d/%0d want 0", i,
                         act_cnt[i][0], act_cnt[i][1], act_cnt[i][2], act_cnt[i][3]);
            else passed++;
        end
        tick(); tick();
        rst = 0;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) tick();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_cnt[i][0] !== 32'd10) $display("FAIL idle_total[%0d] got %0d want 10", i, act_cnt[i][0]);
            else passed++;
            checks++;
            if (act_cnt[i][1] !== 0 || act_cnt[i][2] !== 0 || act_cnt[i][3] !== 0)
                $display("FAIL idle_other[%0d] got %0d/%0d/%0d want 0", i, act_cnt[i][1], act_cnt[i][2], act_cnt[i][3]);
            else passed++;
            checks++;
            if (act_ctrl[i] !== 7'b1101010) $display("FAIL idle_ctrl[%0d] got %b want %b", i, act_ctrl[i], 7'b1101010);
            else passed++;
        end
    endtask

    task automatic test_stall();
        load_use = 1;
        #1;
        checks++;
        if (act_ctrl[0] !== 7'b0001110) $display("FAIL stall_ctrl got %b want %b", act_ctrl[0], 7'b0001110);
        else passed++;
        tick();
        load_use = 0;
        #1;
        checks++;
        if (bb0 !== 32'd1) $display("FAIL stall_bubble got %0d want 1", bb0);
        else passed++;
    endtask

    task automatic test_redirect();
        branch_taken = 1; load_use = 1;
        #1;
        checks++;
        if (act_ctrl[0] !== 7'b1111110) $display("FAIL redirect_ctrl got %b want %b", act_ctrl[0], 7'b1111110);
        else passed++;
        tick();
        branch_taken = 0; load_use = 0; jump_taken = 1;
        #1;
        checks++;
        if (bb0 !== 32'd1 || cb0 !== 32'd1) $display("FAIL redirect_cnt got bubble=%0d condi=%0d want 1/1", bb0, cb0);
        else passed++;
        tick();
        jump_taken = 0;
        #1;
        checks++;
        if (ub0 !== 32'd1) $display("FAIL jump_cnt got %0d want 1", ub0);
        else passed++;
    endtask

    task automatic test_halt();
        logic [31:0] frozen;
        halt_req = 1;
        tick();
        halt_req = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_ctrl[i] !== 7'b0000001) $display("FAIL halt_ctrl[%0d] got %b want %b", i, act_ctrl[i], 7'b0000001);
            else passed++;
        end
        frozen = tc0;
        for (int c = 0; c < 20; c++) tick();
        #1;
        checks++;
        if (tc0 !== frozen) $display("FAIL halt_frozen got %0d want %0d", tc0, frozen);
        else passed++;
        go = 1;
        tick();
        go = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (halted_o[0] !== 1'b1) $display("FAIL go_latency_%0d got halted=%b want 1", c, halted_o[0]);
            else passed++;
            tick();
        end
        halt_req = 1;
        #1;
        checks++;
        if (act_ctrl[0] !== 7'b1101010) $display("FAIL resume_ctrl got %b want %b", act_ctrl[0], 7'b1101010);
        else passed++;
        tick();
        halt_req = 0;
        #1;
        checks++;
        if (halted_o[0] !== 1'b0) $display("FAIL resume_nohalt got halted=%b want 0", halted_o[0]);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (halted_o[i] !== m_halt[i]) $display("FAIL halt_model[%0d] got %b want %b", i, halted_o[i], m_halt[i]);
            else passed++;
        end
        tick();
    endtask

    task automatic test_go_held();
        int resumes [2];
        logic [1:0] prev;
        halt_req = 1; tick(); halt_req = 0;
        resumes[0] = 0; resumes[1] = 0;
        prev = halted_o;
        go = 1;
        for (int c = 0; c < 50; c++) begin
            tick();
            for (int i = 0; i < 2; i++) if (prev[i] && !halted_o[i]) resumes[i]++;
            prev = halted_o;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (resumes[i] != 1) $display("FAIL go_held_resumes[%0d] got %0d want 1", i, resumes[i]);
            else passed++;
        end
        halt_req = 1; tick(); halt_req = 0;
        for (int c = 0; c < 10; c++) tick();
        #1;
        checks++;
        if (halted_o !== 2'b11) $display("FAIL rehalt_held got %b want 11", halted_o);
        else passed++;
        go = 0;
        for (int c = 0; c < 3; c++) tick();
        go = 1; tick(); go = 0;
        for (int c = 0; c < 3; c++) tick();
        #1;
        checks++;
        if (halted_o !== 2'b00) $display("FAIL repress_resume got %b want 00", halted_o);
        else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            halt_req     = ($urandom_range(0, 24) == 0);
            go           = ($urandom_range(0, 3) == 0);
            load_use     = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            jump_taken   = ($urandom_range(0, 7) == 0);
            #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_ctrl[i] !== exp_ctrl(i))
                    $display("FAIL rand_ctrl[%0d] cyc %0d got %b want %b", i, c, act_ctrl[i], exp_ctrl(i));
                else passed++;
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (act_cnt[i][k] !== exp_cnt(i, k))
                        $display("FAIL rand_cnt[%0d][%0d] cyc %0d got %0d want %0d", i, k, c, act_cnt[i][k], exp_cnt(i, k));
                    else passed++;
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_wrap_and_async_reset();
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 17; c++) tick();
        #1;
        checks++;
        if (tc1 !== 4'd1) $display("FAIL wrap_total4 got %0d want 1", tc1);
        else passed++;
        checks++;
        if (tc0 !== 32'd17) $display("FAIL wrap_total32 got %0d want 17", tc0);
        else passed++;
        halt_req = 1; tick(); halt_req = 0;
        tick();
        #2;
        rst = 1;
        #1;
        checks++;
        if (halted_o !== 2'b00) $display("FAIL async_rst_halted got %b want 00", halted_o);
        else passed++;
        checks++;
        if (tc0 !== 0 || tc1 !== 0) $display("FAIL async_rst_cnt got %0d/%0d want 0", tc0, tc1);
        else passed++;
        model_reset();
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_idle();
        test_stall();
        test_redirect();
        test_halt();
        test_go_held();
        test_random();
        test_wrap_and_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
